// File: rtl/systolic_feeder.sv
// Operand sequencer and skew generator for a 3x3 MAC systolic array.
// Buffers matrix A one row per beat and matrix B one column per beat, clears the
// array, then streams the operands diagonally skewed into the left and top edges
// with the array enabled. Flags res_valid once every accumulator holds A x B and
// holds it until the consumer acknowledges with res_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ld_valid / ld_ready   operand beat handshake
//   ld_a_row, ld_b_col    row k of A and column k of B, element m in lane m
//   arr_clr, arr_en       array reset and enable
//   feed_left, feed_top   skewed operand lanes into the array edges
//   busy                  high while clearing or running the array
//   res_valid / res_ready result handshake

module systolic_feeder #(
   parameter int unsigned MATRIX_SIZE = 3,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH   = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ld_valid,
   output logic                              ld_ready,
   input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] ld_a_row,
   input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] ld_b_col,
   output logic                              arr_clr,
   output logic                              arr_en,
   output logic [MATRIX_SIZE*DATA_WIDTH-1:0] feed_left,
   output logic [MATRIX_SIZE*DATA_WIDTH-1:0] feed_top,
   output logic                              busy,
   output logic                              res_valid,
   input  logic                              res_ready
);

   localparam logic [CNT_WIDTH-1:0] NumBeats = CNT_WIDTH'(MATRIX_SIZE);
   localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(MATRIX_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] LastStep = CNT_WIDTH'(3 * MATRIX_SIZE - 3);

   typedef enum logic [1:0] {StLoad, StClear, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] beat_q, beat_d;
   logic [CNT_WIDTH-1:0] step_q, step_d;
   logic                 accept;

   // a_buf[row][col] = A[row][col], b_buf[row][col] = B[row][col]
   logic [DATA_WIDTH-1:0] a_buf [MATRIX_SIZE][MATRIX_SIZE];
   logic [DATA_WIDTH-1:0] b_buf [MATRIX_SIZE][MATRIX_SIZE];

   assign accept = ld_valid & ld_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLoad;
         beat_q  <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         step_q  <= step_d;
      end
   end

   // Operand buffers are deliberately not reset; a fresh load overwrites them.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < int'(MATRIX_SIZE); k++) begin
            if (beat_q == CNT_WIDTH'(k)) begin
               for (int m = 0; m < int'(MATRIX_SIZE); m++) begin
                  a_buf[k][m] <= ld_a_row[m*DATA_WIDTH +: DATA_WIDTH];
                  b_buf[m][k] <= ld_b_col[m*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      step_d  = step_q;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LastBeat) state_d = StClear;
            end
         end
         StClear: begin
            step_d  = '0;
            state_d = StRun;
         end
         StRun: begin
            if (step_q == LastStep) begin
               state_d = StDone;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StDone: begin
            if (res_ready) begin
               state_d = StLoad;
               beat_d  = '0;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // Control outputs; arr_clr follows rst directly so the array clears with us.
   always_comb begin
      ld_ready  = 1'b0;
      arr_clr   = rst;
      arr_en    = 1'b0;
      busy      = 1'b0;
      res_valid = 1'b0;
      unique case (state_q)
         StLoad:  ld_ready = (beat_q < NumBeats);
         StClear: begin
            arr_clr = 1'b1;
            busy    = 1'b1;
         end
         StRun: begin
            arr_en = 1'b1;
            busy   = 1'b1;
         end
         StDone:  res_valid = 1'b1;
         default: ld_ready = 1'b0;
      endcase
   end

   // Skew decode: lane i carries A[i][t-i] (left) / B[t-i][i] (top) when in range.
   // Combinational from step_q so the array samples them on the same edge.
   always_comb begin
      feed_left = '0;
      feed_top  = '0;
      if (state_q == StRun) begin
         for (int i = 0; i < int'(MATRIX_SIZE); i++) begin
            for (int m = 0; m < int'(MATRIX_SIZE); m++) begin
               if (step_q == CNT_WIDTH'(i + m)) begin
                  feed_left[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][m];
                  feed_top[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf[m][i];
               end
            end
         end
      end
   end

endmodule
